// File: rtl/decode_stage.sv
// decode_stage: registered RV32I(+M) decode between fetch and execute.
// Accepts one instruction per cycle and presents the control bundle,
// immediate and register indices on the following cycle. It inserts a
// one-cycle load-use bubble, flags illegal encodings, supports flush, and
// counts stall and issue cycles.
module decode_stage #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned ENABLE_M  = 1,
    parameter int unsigned HAZARD_EN = 1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [31:0]      out_instr,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [31:0]      out_immediate,
    output logic [3:0]       out_alu_op,
    output logic [2:0]       out_xfer_size,
    output logic [2:0]       out_branch_type,
    output logic [1:0]       out_shift_type,
    output logic             out_reg_write,
    output logic             out_alu_src,
    output logic             out_auipc,
    output logic             out_shift,
    output logic             out_slt,
    output logic             out_mem_write,
    output logic             out_mem_read,
    output logic             out_mem_to_reg,
    output logic             out_jump,
    output logic             out_jalr,
    output logic             out_is_unsigned,
    output logic             out_muldiv,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] issue_cnt
);

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_FENCE  = 7'b0001111
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_PASS = 4'd5
    } alu_op_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic [3:0]      alu_op;
        logic [2:0]      xfer_size;
        logic [2:0]      branch_type;
        logic [1:0]      shift_type;
        logic            reg_write;
        logic            alu_src;
        logic            auipc;
        logic            shift;
        logic            slt;
        logic            mem_write;
        logic            mem_read;
        logic            mem_to_reg;
        logic            jump;
        logic            jalr;
        logic            is_unsigned;
        logic            muldiv;
        logic            illegal;
    } bundle_t;

    opcode_e     opcode;
    logic [4:0]  f_rd, f_rs1, f_rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = opcode_e'(in_instr[6:0]);
    assign f_rd   = in_instr[11:7];
    assign f3     = in_instr[14:12];
    assign f_rs1  = in_instr[19:15];
    assign f_rs2  = in_instr[24:20];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};

    bundle_t dec;
    logic    legal, uses_rs1, uses_rs2;

    // Combinational decode of the incoming instruction into a control bundle.
    always_comb begin
        dec           = '0;
        dec.pc        = in_pc;
        dec.instr     = in_instr;
        dec.xfer_size = 3'd4;
        legal         = 1'b1;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec.rd = f_rd; dec.imm = imm_u; dec.alu_op = ALU_PASS;
                dec.alu_src = 1'b1; dec.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                dec.rd = f_rd; dec.imm = imm_u; dec.alu_op = ALU_ADD;
                dec.alu_src = 1'b1; dec.auipc = 1'b1; dec.reg_write = 1'b1;
            end
            OP_JAL: begin
                dec.rd = f_rd; dec.imm = imm_j;
                dec.jump = 1'b1; dec.reg_write = 1'b1;
            end
            OP_JALR: begin
                dec.rd = f_rd; dec.rs1 = f_rs1; dec.imm = imm_i;
                dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.jump = 1'b1; dec.jalr = 1'b1; uses_rs1 = 1'b1;
                if (f3 != 3'b000) legal = 1'b0;
            end
            OP_BRANCH: begin
                dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.imm = imm_b;
                dec.alu_op = ALU_SUB; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                case (f3)
                    3'b000: dec.branch_type = 3'd1;
                    3'b001: dec.branch_type = 3'd2;
                    3'b100: dec.branch_type = 3'd3;
                    3'b101: dec.branch_type = 3'd4;
                    3'b110: begin dec.branch_type = 3'd5; dec.is_unsigned = 1'b1; end
                    3'b111: begin dec.branch_type = 3'd6; dec.is_unsigned = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                dec.rd = f_rd; dec.rs1 = f_rs1; dec.imm = imm_i;
                dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; uses_rs1 = 1'b1;
                case (f3)
                    3'b000: dec.xfer_size = 3'd1;
                    3'b001: dec.xfer_size = 3'd2;
                    3'b010: dec.xfer_size = 3'd4;
                    3'b100: begin dec.xfer_size = 3'd1; dec.is_unsigned = 1'b1; end
                    3'b101: begin dec.xfer_size = 3'd2; dec.is_unsigned = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.imm = imm_s;
                dec.alu_src = 1'b1; dec.mem_write = 1'b1;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                case (f3)
                    3'b000: dec.xfer_size = 3'd1;
                    3'b001: dec.xfer_size = 3'd2;
                    3'b010: dec.xfer_size = 3'd4;
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                dec.rd = f_rd; dec.rs1 = f_rs1; dec.imm = imm_i;
                dec.alu_src = 1'b1; dec.reg_write = 1'b1; uses_rs1 = 1'b1;
                case (f3)
                    3'b000: dec.alu_op = ALU_ADD;
                    3'b010: begin dec.alu_op = ALU_SUB; dec.slt = 1'b1; end
                    3'b011: begin dec.alu_op = ALU_SUB; dec.slt = 1'b1; dec.is_unsigned = 1'b1; end
                    3'b100: dec.alu_op = ALU_XOR;
                    3'b110: dec.alu_op = ALU_OR;
                    3'b111: dec.alu_op = ALU_AND;
                    3'b001: begin
                        dec.shift = 1'b1; dec.shift_type = 2'd0;
                        if (f7 != 7'b0000000) legal = 1'b0;
                    end
                    default: begin
                        dec.shift = 1'b1;
                        if (f7 == 7'b0000000)      dec.shift_type = 2'd1;
                        else if (f7 == 7'b0100000) dec.shift_type = 2'd2;
                        else                       legal = 1'b0;
                    end
                endcase
            end
            OP_REG: begin
                dec.rd = f_rd; dec.rs1 = f_rs1; dec.rs2 = f_rs2;
                dec.reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                if (f7 == 7'b0000001) begin
                    if (ENABLE_M != 0) begin
                        dec.muldiv = 1'b1; dec.alu_op = {1'b1, f3};
                    end else begin
                        legal = 1'b0;
                    end
                end else if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: dec.alu_op = ALU_ADD;
                        3'b001: begin dec.shift = 1'b1; dec.shift_type = 2'd0; end
                        3'b010: begin dec.alu_op = ALU_SUB; dec.slt = 1'b1; end
                        3'b011: begin dec.alu_op = ALU_SUB; dec.slt = 1'b1; dec.is_unsigned = 1'b1; end
                        3'b100: dec.alu_op = ALU_XOR;
                        3'b101: begin dec.shift = 1'b1; dec.shift_type = 2'd1; end
                        3'b110: dec.alu_op = ALU_OR;
                        default: dec.alu_op = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    case (f3)
                        3'b000: dec.alu_op = ALU_SUB;
                        3'b101: begin dec.shift = 1'b1; dec.shift_type = 2'd2; end
                        default: legal = 1'b0;
                    endcase
                end else begin
                    legal = 1'b0;
                end
            end
            OP_FENCE: ;
            default: legal = 1'b0;
        endcase
        // An illegal encoding keeps only pc/instr so nothing downstream acts on it.
        if (!legal) begin
            dec           = '0;
            dec.pc        = in_pc;
            dec.instr     = in_instr;
            dec.xfer_size = 3'd4;
            dec.illegal   = 1'b1;
            uses_rs1      = 1'b0;
            uses_rs2      = 1'b0;
        end
    end

    bundle_t            bundle_q, bundle_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   stall_q, stall_d, issue_q, issue_d;
    logic               hazard, accept, fire;

    assign hazard = (HAZARD_EN != 0) && in_valid && valid_q && bundle_q.mem_read
                    && (bundle_q.rd != 5'd0)
                    && ((uses_rs1 && (f_rs1 == bundle_q.rd)) ||
                        (uses_rs2 && (f_rs2 == bundle_q.rd)));
    assign in_ready = !reset && !flush && !hazard && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign fire     = valid_q && out_ready;

    // Next-state for the output register and the performance counters.
    always_comb begin
        bundle_d = bundle_q;
        valid_d  = valid_q;
        stall_d  = stall_q;
        issue_d  = issue_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            bundle_d = dec;
            valid_d  = 1'b1;
        end else if (fire) begin
            valid_d = 1'b0;
        end
        if (in_valid && hazard && !flush) stall_d = stall_q + CNT_W'(1);
        if (fire && !flush)               issue_d = issue_q + CNT_W'(1);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bundle_q <= '0;
            valid_q  <= 1'b0;
            stall_q  <= '0;
            issue_q  <= '0;
        end else begin
            bundle_q <= bundle_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
            issue_q  <= issue_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_pc          = bundle_q.pc;
    assign out_instr       = bundle_q.instr;
    assign out_rd          = bundle_q.rd;
    assign out_rs1         = bundle_q.rs1;
    assign out_rs2         = bundle_q.rs2;
    assign out_immediate   = bundle_q.imm;
    assign out_alu_op      = bundle_q.alu_op;
    assign out_xfer_size   = bundle_q.xfer_size;
    assign out_branch_type = bundle_q.branch_type;
    assign out_shift_type  = bundle_q.shift_type;
    assign out_reg_write   = bundle_q.reg_write;
    assign out_alu_src     = bundle_q.alu_src;
    assign out_auipc       = bundle_q.auipc;
    assign out_shift       = bundle_q.shift;
    assign out_slt         = bundle_q.slt;
    assign out_mem_write   = bundle_q.mem_write;
    assign out_mem_read    = bundle_q.mem_read;
    assign out_mem_to_reg  = bundle_q.mem_to_reg;
    assign out_jump        = bundle_q.jump;
    assign out_jalr        = bundle_q.jalr;
    assign out_is_unsigned = bundle_q.is_unsigned;
    assign out_muldiv      = bundle_q.muldiv;
    assign out_illegal     = bundle_q.illegal;
    assign stall_cnt       = stall_q;
    assign issue_cnt       = issue_q;

endmodule
